// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word fetches and buffers {pc, inst} for decode.
// Optional build macro IFU_MISALIGN_CHK_EN: misaligned redirects set a sticky error and halt fetch.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFU_MISALIGN_CHK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            req_valid_q, req_valid_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     pc_mem   [FIFO_DEPTH];
    logic [31:0]     inst_mem [FIFO_DEPTH];

    logic            redir;
    logic [31:0]     redir_pc;
    logic            fire;
    logic            push;
    logic            pop;
    logic            outstanding;
    logic [CW-1:0]   count_after;
    logic            room_after;

`ifdef IFU_MISALIGN_CHK_EN
    logic            misalign_q, misalign_d;
    logic            halt_pend_q, halt_pend_d;
    logic            redir_misaligned;

    // Once the error is latched, fetch is frozen and further redirects are ignored.
    assign redir            = redirect_valid & ~misalign_q;
    assign redir_pc         = redirect_pc;
    assign redir_misaligned = redir & (redirect_pc[1:0] != 2'b00);
    assign misalign_err     = misalign_q;
`else
    logic            unused_redir_lsb;

    assign redir            = redirect_valid;
    assign redir_pc         = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign misalign_err     = 1'b0;
`endif

    assign inst_valid     = (count_q != '0);
    assign inst           = inst_valid ? inst_mem[rd_ptr_q] : NOP;
    assign inst_pc        = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_valid_q ? fetch_pc_q : 32'h0;

    assign fire        = req_valid_q & imem_req_ready;
    assign push        = (state_q == S_WAIT) & imem_rsp_valid & ~drop_q & ~redir;
    assign pop         = inst_valid & inst_ready & ~redir;
    assign count_after = count_q + CW'(push) - CW'(pop);
    assign room_after  = (count_after < CW'(FIFO_DEPTH));
    // A response arriving in the redirect cycle is simply discarded, so it no longer counts as outstanding.
    assign outstanding = fire | ((state_q == S_WAIT) & ~imem_rsp_valid);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        count_d    = count_after;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
`ifdef IFU_MISALIGN_CHK_EN
        misalign_d  = misalign_q;
        halt_pend_d = halt_pend_q;
`endif

        case (state_q)
            S_REQ: begin
                if (fire) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    req_addr_d = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    drop_d = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
                    if (halt_pend_q) begin
                        state_d     = S_HALT;
                        halt_pend_d = 1'b0;
                    end else
`endif
                    if (room_after) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (pop) begin
                    state_d = S_REQ;
                end
            end
`ifdef IFU_MISALIGN_CHK_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redir) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redir_pc;
            drop_d     = outstanding;
            state_d    = outstanding ? S_WAIT : S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
            if (redir_misaligned) begin
                misalign_d = 1'b1;
                if (outstanding) begin
                    halt_pend_d = 1'b1;
                end else begin
                    state_d = S_HALT;
                end
            end
`endif
        end

        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= 32'h0;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
            halt_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q  <= misalign_d;
            halt_pend_q <= halt_pend_d;
`endif
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_addr_q;
            inst_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch with a small instruction-memory responder of configurable latency.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;

    int          tests_run;
    int          tests_failed;
    logic        mem_ready_en;
    int          mem_lat;
    int          pend_cnt;
    logic [31:0] pend_data;

    ifu_fetch #(
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: one response mem_lat cycles after each accepted request.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pend_cnt       = 0;
        pend_data      = 32'h0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend_cnt = 0;
            end else if (pend_cnt != 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend_data;
                end
            end
            imem_req_ready = mem_ready_en;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend_cnt  = mem_lat;
                pend_data = mem_word(imem_req_addr);
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_ready_en   = 1'b1;
        mem_lat        = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({inst_valid, imem_req_valid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_precond: got %b, expected 11", {inst_valid, imem_req_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst, misalign_err} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0013, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%b addr=%h iv=%b pc=%h inst=%h err=%b, expected 0 0 0 0 00000013 0",
                     imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst, misalign_err);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_addr = 32'h8000_0000 + 32'(4 * i);
            exp_pc   = exp_addr - 32'd4;
            @(negedge clk);
            tests_run++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, exp_addr}) begin
                tests_failed++;
                $display("FAIL stream_req[%0d]: got %b/%h, expected 1/%h", i, imem_req_valid, imem_req_addr, exp_addr);
            end
            if (i > 0) begin
                tests_run++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
                    tests_failed++;
                    $display("FAIL stream_inst[%0d]: got %b/%h/%h, expected 1/%h/%h", i, inst_valid, inst_pc, inst,
                             exp_pc, mem_word(exp_pc));
                end
            end
            @(negedge clk);
            tests_run++;
            if ({imem_req_valid, inst_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL stream_bubble[%0d]: got %b, expected 00", i, {imem_req_valid, inst_valid});
            end
        end
    endtask

    task automatic test_stall();
        int reqs;
        do_reset();
        inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({inst_valid, inst_pc, imem_req_valid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %b/%h/%b, expected 1/80000000/0", i, inst_valid, inst_pc,
                         imem_req_valid);
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        tests_run++;
        if ({inst_valid, inst_pc, imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0004, 1'b1, 32'h8000_0008}) begin
            tests_failed++;
            $display("FAIL stall_pop: got %b/%h/%b/%h, expected 1/80000004/1/80000008", inst_valid, inst_pc,
                     imem_req_valid, imem_req_addr);
        end
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            if (imem_req_valid) reqs++;
            @(negedge clk);
        end
        tests_run++;
        if (reqs !== 1) begin
            tests_failed++;
            $display("FAIL stall_one_req: got %0d requests, expected 1", reqs);
        end
    endtask

    task automatic test_redirect_drop();
        logic found;
        do_reset();
        mem_lat    = 2;
        inst_ready = 1'b1;
        found      = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h8000_0008) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL drop_wait_req: got no request to 80000008, expected one within 40 cycles");
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if ({inst_valid, imem_req_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL drop_wait: got %b, expected 00", {inst_valid, imem_req_valid});
        end
        @(negedge clk);
        tests_run++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin
            tests_failed++;
            $display("FAIL drop_new_req: got %b/%b/%h, expected 0/1/80000100", inst_valid, imem_req_valid,
                     imem_req_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_empty: got %b, expected 0", inst_valid);
        end
        @(negedge clk);
        tests_run++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h8000_0100, mem_word(32'h8000_0100)}) begin
            tests_failed++;
            $display("FAIL drop_target_inst: got %b/%h/%h, expected 1/80000100/%h", inst_valid, inst_pc, inst,
                     mem_word(32'h8000_0100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic found;
        do_reset();
        inst_ready = 1'b0;
        found      = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h8000_0004) found = 1'b1;
        end
        tests_run++;
        if (!found || {inst_valid, inst_pc} !== {1'b1, 32'h8000_0000}) begin
            tests_failed++;
            $display("FAIL same_precond: got found=%b iv=%b pc=%h, expected 1/1/80000000", found, inst_valid, inst_pc);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0200}) begin
            tests_failed++;
            $display("FAIL same_flush: got %b/%b/%h, expected 0/1/80000200", inst_valid, imem_req_valid, imem_req_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h8000_0200}) begin
            tests_failed++;
            $display("FAIL same_no_drop: got %b/%h, expected 1/80000200", inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            tests_failed++;
            $display("FAIL wrap_first: got %b/%h, expected 1/fffffffc", imem_req_valid, imem_req_addr);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst_pc} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}) begin
            tests_failed++;
            $display("FAIL wrap_next: got %b/%h/%b/%h, expected 1/00000000/1/fffffffc", imem_req_valid, imem_req_addr,
                     inst_valid, inst_pc);
        end
    endtask

`ifdef IFU_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({misalign_err, imem_req_valid, inst_valid} !== 3'b100) begin
                tests_failed++;
                $display("FAIL misalign_halt[%0d]: got %b, expected 100", i, {misalign_err, imem_req_valid, inst_valid});
            end
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({misalign_err, imem_req_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL misalign_ignore: got %b, expected 10", {misalign_err, imem_req_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_clear: got %b, expected 0", misalign_err);
        end
    endtask
`else
    task automatic test_force_align();
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if ({misalign_err, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin
            tests_failed++;
            $display("FAIL force_align: got %b/%b/%h, expected 0/1/80000100", misalign_err, imem_req_valid,
                     imem_req_addr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_ready_en   = 1'b1;
        mem_lat        = 1;
        #1;
        tests_run++;
        if ({imem_req_valid, inst_valid, inst, inst_pc} !== {1'b0, 1'b0, 32'h0000_0013, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_initial: got %b/%b/%h/%h, expected 0/0/00000013/00000000", imem_req_valid,
                     inst_valid, inst, inst_pc);
        end
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
`ifdef IFU_MISALIGN_CHK_EN
        test_misalign();
`else
        test_force_align();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that sits directly upstream of the decode/control stage. It owns the PC and issues one word fetch at a time to instruction memory over a valid/ready request channel. Returned words are buffered in a small FIFO of {pc, inst} pairs and presented to decode with a valid/ready handshake. Decode itself is purely combinational on `inst`. Taken branches and jumps resolved downstream redirect the PC and flush in-flight work.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `redirect_valid`  in  1  taken branch/jump/jalr resolved this cycle.
- `redirect_pc`  in  32  target PC.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  32  fetch address; memory samples it only on valid&ready.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_rsp_valid`  in  1  response word valid; exactly one per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  32  head instruction; 32'h0000_0013 (NOP) when `inst_valid`=0, so the decode-side DPI checks never fire on bubbles.
- `inst_pc`  out  32  head PC; 0 when `inst_valid`=0.
- `inst_ready`  in  1  decode consumes head.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers: `fetch_pc`, FIFO (`count`, rd/wr pointers), `drop` flag, FSM.
- FSM states: S_REQ (request asserted), S_WAIT (one request outstanding), S_STALL (no room), S_HALT (misalign, macro only).
- Room condition: `count` < FIFO_DEPTH, with the outstanding slot reserved.
- S_REQ: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`. On ready, `fetch_pc` += 4 (mod 2^32, wraps silently) and go to S_WAIT.
- S_WAIT: on `imem_rsp_valid`:
  - if `drop`=0, push {addr, data}; else discard and clear `drop`.
  - Then go to S_REQ if room remains after the push, else S_STALL.
- S_STALL: go to S_REQ once a pop frees an entry.
- Pop on `inst_valid & inst_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect, highest priority:
  - FIFO flushed (`count`=0).
  - `fetch_pc` ← `redirect_pc`.
  - Same-cycle pop and push are suppressed.
  - If a request is outstanding (S_WAIT, or S_REQ accepted this cycle), set `drop` and enter S_WAIT; otherwise enter S_REQ.
  - A redirect while `drop` is already set keeps `drop` set and only updates `fetch_pc`.
  - An unaccepted request is withdrawn; next cycle the address is the new PC.
- At most one request is ever outstanding.

## Timing
- Reset (async assert):
  - all outputs low/0 except `inst`=NOP;
  - `fetch_pc`=RESET_PC, FSM=S_REQ, `count`=0, `drop`=0.
  - First request is on the first clock edge after deassertion.
- Response captured at edge N → `inst_valid` at N+1. There is no bypass from response to output.
- Peak throughput is one instruction per 2 cycles with single-cycle memory: request accepted at cycle N, response at N+1, next request at N+2.
- Redirect at cycle R → request to the target PC at R+1 if nothing is outstanding. Otherwise the request follows the cycle after the dropped response.
- Redirect and response in the same cycle: the response is dropped and `drop` is not set.
- `inst`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration
- `IFU_MISALIGN_CHK_EN` defined:
  - a redirect with `redirect_pc[1:0]` ≠ 0 still flushes, and sets `misalign_err`=1 (sticky until reset);
  - FSM enters S_HALT once any outstanding response has drained;
  - `imem_req_valid` stays 0 and later redirects are ignored.
- Undefined: `redirect_pc[1:0]` is forced to 00, S_HALT does not exist, `misalign_err` is tied 0.

## Test plan
- Reset release, memory always ready with 1-cycle response, `inst_ready`=1 → requests 0x8000_0000, 0x8000_0004…; `inst_pc` matches each; `inst_valid` every other cycle.
- `inst_ready`=0 → after two responses `count`=2, FSM S_STALL, `imem_req_valid`=0. One pop → exactly one new request.
- Request to 0x8000_0008 accepted; redirect to 0x8000_0100 the next cycle, before the response → stale word discarded, FIFO empty, next request 0x8000_0100.
- Redirect to 0x8000_0200 in the same cycle as `inst_ready`=1 and a response → no pop/push observed, `inst_valid`=0 next cycle.
- `fetch_pc`=0xFFFF_FFFC → next address 0x0000_0000.
- With `IFU_MISALIGN_CHK_EN`, redirect to 0x8000_0102 → `misalign_err`=1, no further requests; rst_n low clears `misalign_err` asynchronously.
